// File: rtl/inst_dispatch_pkg.sv
// Shared types and constants for the instruction dispatch stage:
// functional-unit classes, RV32 major opcodes and the dispatch FSM states.
package disp_pkg;

   typedef enum logic [1:0] {
      FU_ALU   = 2'd0,
      FU_LSU   = 2'd1,
      FU_BR    = 2'd2,
      FU_OTHER = 2'd3
   } fu_e;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_e;

   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_OP_IMM = 7'b0010011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

endpackage

// File: rtl/inst_dispatch_if.sv
// Bundle of the fifo-side, RS/ROB-side and control signals of the dispatch
// stage. "master" is the dispatch stage itself, "slave" its surroundings.
interface inst_dispatch_if #(
   parameter int unsigned INST_W = 32,
   parameter int unsigned TAG_W  = 4
);
   logic [INST_W-1:0] fifo_data_i;
   logic              fifo_empty_i;
   logic              fifo_rd_o;
   logic              disp_valid_o;
   logic              disp_ready_i;
   logic [INST_W-1:0] disp_inst_o;
   logic [TAG_W-1:0]  disp_tag_o;
   logic [1:0]        disp_fu_o;
   logic              rob_retire_i;
   logic              rs_credit_i;
   logic              flush_i;
   logic              stall_o;

   modport master (
      input  fifo_data_i, fifo_empty_i, disp_ready_i, rob_retire_i, rs_credit_i, flush_i,
      output fifo_rd_o, disp_valid_o, disp_inst_o, disp_tag_o, disp_fu_o, stall_o
   );

   modport slave (
      output fifo_data_i, fifo_empty_i, disp_ready_i, rob_retire_i, rs_credit_i, flush_i,
      input  fifo_rd_o, disp_valid_o, disp_inst_o, disp_tag_o, disp_fu_o, stall_o
   );
endinterface

// File: rtl/inst_dispatch_updown_ctr.sv
// Saturating up/down counter. inc and dec together leave the count unchanged;
// load (and reset) restore RST_VAL. Increments at MAX and decrements at 0 are dropped.
module disp_updown_ctr #(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned MAX     = 8,
   parameter int unsigned RST_VAL = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             inc,
   input  logic             dec,
   output logic [WIDTH-1:0] cnt
);
   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
   localparam logic [WIDTH-1:0] RST_V = WIDTH'(RST_VAL);

   // count register with reset/load priority over inc/dec
   always_ff @(posedge clk) begin
      if (rst || load) begin
         cnt <= RST_V;
      end else if (inc && !dec && cnt != MAX_V) begin
         cnt <= cnt + WIDTH'(1);
      end else if (dec && !inc && cnt != '0) begin
         cnt <= cnt - WIDTH'(1);
      end
   end
endmodule

// File: rtl/inst_dispatch.sv
// Dispatch stage: pops the instruction fifo head, allocates a ROB tag, checks RS
// credits, classifies the FU and presents it on a registered valid/ready port.
// Optional DISP_PERF_EN adds saturating stall-cause counters.
module inst_dispatch
   import disp_pkg::*;
#(
   parameter int unsigned INST_W     = 32,
   parameter int unsigned TAG_W      = 4,
   parameter int unsigned RS_CREDITS = 4,
   parameter int unsigned CRED_W     = 3
) (
   input  logic              clk_i,
   input  logic              reset_i,
   inst_dispatch_if.master   bus
`ifdef DISP_PERF_EN
   ,
   output logic [15:0]       perf_rob_stall_o,
   output logic [15:0]       perf_rs_stall_o
`endif
);
   localparam logic [TAG_W:0] ROB_DEPTH = {1'b1, {TAG_W{1'b0}}};

   state_e            state;
   logic [TAG_W:0]    rob_cnt;
   logic [CRED_W-1:0] credits;
   logic [TAG_W-1:0]  tail;
   logic              disp_valid;
   logic [INST_W-1:0] disp_inst;
   logic [TAG_W-1:0]  disp_tag;
   fu_e               disp_fu;
   fu_e               fu_dec;
   logic              run, rob_full, cred_zero, pop, stall;

   assign run       = (state == ST_RUN);
   assign rob_full  = (rob_cnt == ROB_DEPTH);
   assign cred_zero = (credits == '0);
   assign pop       = run && !bus.fifo_empty_i && (!disp_valid || bus.disp_ready_i)
                      && !rob_full && !cred_zero && !bus.flush_i;
   assign stall     = run && !bus.fifo_empty_i && !pop;

   assign bus.fifo_rd_o    = pop;
   assign bus.stall_o      = stall;
   assign bus.disp_valid_o = disp_valid;
   assign bus.disp_inst_o  = disp_inst;
   assign bus.disp_tag_o   = disp_tag;
   assign bus.disp_fu_o    = disp_fu;

   // ROB occupancy: +1 per pop, -1 per retire, cleared by flush
   disp_updown_ctr #(
      .WIDTH   (TAG_W + 1),
      .MAX     (1 << TAG_W),
      .RST_VAL (0)
   ) u_rob_ctr (
      .clk  (clk_i),
      .rst  (reset_i),
      .load (bus.flush_i),
      .inc  (pop),
      .dec  (bus.rob_retire_i),
      .cnt  (rob_cnt)
   );

   // RS credits: -1 per pop, +1 per returned slot, refilled by flush
   disp_updown_ctr #(
      .WIDTH   (CRED_W),
      .MAX     (RS_CREDITS),
      .RST_VAL (RS_CREDITS)
   ) u_cred_ctr (
      .clk  (clk_i),
      .rst  (reset_i),
      .load (bus.flush_i),
      .inc  (bus.rs_credit_i),
      .dec  (pop),
      .cnt  (credits)
   );

   // FU classification from the major opcode of the fifo head
   always_comb begin
      fu_dec = FU_OTHER;
      case (bus.fifo_data_i[6:0])
         OP_OP, OP_OP_IMM, OP_LUI, OP_AUIPC: fu_dec = FU_ALU;
         OP_LOAD, OP_STORE:                  fu_dec = FU_LSU;
         OP_BRANCH, OP_JAL, OP_JALR:         fu_dec = FU_BR;
         default:                            fu_dec = FU_OTHER;
      endcase
   end

   // RUN/FLUSH state machine with registered dispatch outputs and tag tail
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state      <= ST_RUN;
         disp_valid <= 1'b0;
         disp_inst  <= '0;
         disp_tag   <= '0;
         disp_fu    <= FU_ALU;
         tail       <= '0;
      end else if (bus.flush_i) begin
         state      <= ST_FLUSH;
         disp_valid <= 1'b0;
         tail       <= '0;
      end else begin
         state <= ST_RUN;
         if (pop) begin
            disp_valid <= 1'b1;
            disp_inst  <= bus.fifo_data_i;
            disp_tag   <= tail;
            disp_fu    <= fu_dec;
            tail       <= tail + TAG_W'(1);
         end else if (disp_valid && bus.disp_ready_i) begin
            disp_valid <= 1'b0;
         end
      end
   end

`ifdef DISP_PERF_EN
   // stall-cause counters, saturating, cleared by reset only
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         perf_rob_stall_o <= '0;
         perf_rs_stall_o  <= '0;
      end else begin
         if (stall && rob_full && perf_rob_stall_o != '1) begin
            perf_rob_stall_o <= perf_rob_stall_o + 16'd1;
         end
         if (stall && cred_zero && perf_rs_stall_o != '1) begin
            perf_rs_stall_o <= perf_rs_stall_o + 16'd1;
         end
      end
   end
`endif
endmodule

// File: tb/tb_inst_dispatch.sv
// Randomized scoreboard bench for inst_dispatch: a reference model tracks fifo
// contents, ROB occupancy, credits and next tag as plain integers/queues.
module tb_inst_dispatch;
   import disp_pkg::*;

   localparam int unsigned INST_W = 32;
   localparam int unsigned TAG_W  = 4;
   localparam int          ROB_N  = 16;
   localparam int          CRED_N = 4;
   localparam int          NCYC   = 2400;

   logic clk = 1'b0;
   logic reset_i;
   always #5 clk = ~clk;

   inst_dispatch_if #(.INST_W(INST_W), .TAG_W(TAG_W)) bus ();

`ifdef DISP_PERF_EN
   logic [15:0] perf_rob, perf_rs;
`endif

   inst_dispatch #(
      .INST_W     (INST_W),
      .TAG_W      (TAG_W),
      .RS_CREDITS (CRED_N),
      .CRED_W     (3)
   ) dut (
      .clk_i   (clk),
      .reset_i (reset_i),
      .bus     (bus)
`ifdef DISP_PERF_EN
      ,
      .perf_rob_stall_o (perf_rob),
      .perf_rs_stall_o  (perf_rs)
`endif
   );

   typedef struct {
      logic [31:0] inst;
      int          tag;
      int          fu;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] fifo_q[$];
   int          rob_used, credits, next_tag;
   bit          flushing, active, exp_pop, exp_stall;
   int          n_vec, n_fail;
   int          perf_rob_m, perf_rs_m;

   logic [6:0] ops [11] = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b0000011,
                            7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111, 7'b1110011,
                            7'b0001111};
   int p_ready  [4] = '{100, 100, 70, 40};
   int p_retire [4] = '{0, 0, 30, 50};
   int p_credit [4] = '{0, 90, 60, 50};
   int p_flush  [4] = '{0, 0, 3, 2};
   int p_push   [4] = '{90, 90, 70, 50};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic int fu_of(input logic [31:0] w);
      case (w[6:0])
         7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: return 0;
         7'b0000011, 7'b0100011:                         return 1;
         7'b1100011, 7'b1101111, 7'b1100111:             return 2;
         default:                                        return 3;
      endcase
   endfunction

   function automatic bit chance(input int pct);
      return $urandom_range(99) < pct;
   endfunction

   task automatic set_inputs(input int ph);
      logic [31:0] w;
      if (chance(p_push[ph]) && fifo_q.size() < 8) begin
         w = $urandom;
         if (chance(75)) w[6:0] = ops[$urandom_range(10)];
         fifo_q.push_back(w);
      end
      bus.fifo_empty_i = (fifo_q.size() == 0);
      bus.fifo_data_i  = (fifo_q.size() != 0) ? fifo_q[0] : $urandom;
      bus.disp_ready_i = chance(p_ready[ph]);
      bus.rob_retire_i = chance(p_retire[ph]);
      bus.rs_credit_i  = chance(p_credit[ph]);
      bus.flush_i      = chance(p_flush[ph]);
      exp_pop   = !flushing && fifo_q.size() != 0 && (exp_q.size() == 0 || bus.disp_ready_i)
                  && rob_used < ROB_N && credits > 0 && !bus.flush_i;
      exp_stall = !flushing && fifo_q.size() != 0 && !exp_pop;
   endtask

   task automatic update_model();
      if (exp_stall && rob_used == ROB_N && perf_rob_m < 65535) perf_rob_m++;
      if (exp_stall && credits == 0 && perf_rs_m < 65535) perf_rs_m++;
      if (bus.flush_i) begin
         exp_q.delete();
         rob_used = 0;
         credits  = CRED_N;
         next_tag = 0;
         flushing = 1'b1;
      end else begin
         flushing = 1'b0;
         if (exp_pop) begin
            exp_q.push_back('{fifo_q[0], next_tag, fu_of(fifo_q[0])});
            void'(fifo_q.pop_front());
            next_tag = (next_tag + 1) % ROB_N;
         end
         if (!(exp_pop && bus.rob_retire_i)) begin
            if (exp_pop) rob_used++;
            else if (bus.rob_retire_i && rob_used > 0) rob_used--;
         end
         if (!(exp_pop && bus.rs_credit_i)) begin
            if (exp_pop) credits--;
            else if (bus.rs_credit_i && credits < CRED_N) credits++;
         end
      end
   endtask

   // monitor: compares handshake outputs against the scoreboard every cycle
   always @(negedge clk) begin
      exp_t e;
      if (active) begin
         check("fifo_rd", bus.fifo_rd_o, exp_pop);
         check("stall", bus.stall_o, exp_stall);
         check("valid", bus.disp_valid_o, exp_q.size() != 0);
         if (bus.disp_valid_o && bus.disp_ready_i && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("inst", bus.disp_inst_o, e.inst);
            check("tag", bus.disp_tag_o, e.tag);
            check("fu", bus.disp_fu_o, e.fu);
         end
`ifdef DISP_PERF_EN
         check("perf_rob", perf_rob, perf_rob_m);
         check("perf_rs", perf_rs, perf_rs_m);
`endif
      end
   end

   initial begin
      n_vec = 0; n_fail = 0; active = 1'b0;
      rob_used = 0; credits = CRED_N; next_tag = 0; flushing = 1'b0;
      perf_rob_m = 0; perf_rs_m = 0; exp_pop = 1'b0; exp_stall = 1'b0;
      reset_i          = 1'b1;
      bus.fifo_empty_i = 1'b1;
      bus.fifo_data_i  = '0;
      bus.disp_ready_i = 1'b0;
      bus.rob_retire_i = 1'b0;
      bus.rs_credit_i  = 1'b0;
      bus.flush_i      = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valid", bus.disp_valid_o, 0);
      check("rst_inst", bus.disp_inst_o, 0);
      check("rst_tag", bus.disp_tag_o, 0);
      check("rst_fu", bus.disp_fu_o, 0);
      check("rst_fifo_rd", bus.fifo_rd_o, 0);
      check("rst_stall", bus.stall_o, 0);
      @(posedge clk);
      #1;
      reset_i = 1'b0;
      active  = 1'b1;
      set_inputs(0);
      for (int c = 1; c < NCYC; c++) begin
         @(posedge clk);
         update_model();
         #1;
         set_inputs(c / (NCYC / 4));
      end
      @(negedge clk);
      #1;
      active = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
